// File: rtl/fp_mult_mantissa_seq_if.sv
// Handshake and data bundle between the binary32 operand source and the
// mantissa-multiplier front end.
interface fp_mult_mantissa_seq_if #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           a;
    logic [31:0]           b;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*MANT_W-1:0]   P;
    logic [EXP_W+1:0]      S;
    logic                  sign;
    logic                  zero;
    logic                  special;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, P, S, sign, zero, special
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, P, S, sign, zero, special
    );
endinterface

// File: rtl/fp_mult_mantissa_seq.sv
// Binary32 multiplier front end: unpacks operands, sums exponents and forms
// the raw 48-bit significand product with a radix-2 shift-add loop.
module fp_mult_mantissa_seq #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned BIAS   = 127
) (
    input logic                   clk,
    input logic                   rst,
    fp_mult_mantissa_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(MANT_W);
    localparam int unsigned SW   = EXP_W + 2;
    localparam int unsigned PW   = 2 * MANT_W;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [MANT_W-1:0]   mcand_q, mcand_d;
    logic [MANT_W-1:0]   mplr_q, mplr_d;
    logic [MANT_W:0]     acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]       p_q, p_d;
    logic [SW-1:0]       s_q, s_d;
    logic                sign_q, sign_d;
    logic                zero_q, zero_d;
    logic                special_q, special_d;

    logic [EXP_W-1:0]    ea, eb;
    logic                op_zero, op_inf;
    logic [SW-1:0]       exp_sum;
    logic [MANT_W:0]     sum;
    logic [PW:0]         shifted;

    assign ea      = bus.a[MANT_W-1 +: EXP_W];
    assign eb      = bus.b[MANT_W-1 +: EXP_W];
    assign op_zero = (ea == '0) || (eb == '0);
    assign op_inf  = (ea == '1) || (eb == '1);
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - SW'(BIAS);

    // Carry out of the add lands in sum[MANT_W] and shifts down into acc bit MANT_W-1.
    assign sum     = acc_q + {1'b0, (mplr_q[0] ? mcand_q : '0)};
    assign shifted = {sum, mplr_q} >> 1;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        s_d       = s_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        special_d = special_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mcand_d   = {1'b1, bus.a[MANT_W-2:0]};
                    mplr_d    = {1'b1, bus.b[MANT_W-2:0]};
                    acc_d     = '0;
                    cnt_d     = '0;
                    sign_d    = bus.a[31] ^ bus.b[31];
                    zero_d    = op_zero;
                    special_d = op_inf && !op_zero;
                    if (op_zero) begin
                        p_d     = '0;
                        s_d     = '0;
                        state_d = StDone;
                    end else begin
                        s_d     = exp_sum;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                acc_d  = shifted[PW:MANT_W];
                mplr_d = shifted[MANT_W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntW'(MANT_W - 1)) begin
                    p_d     = shifted[PW-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            s_q       <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            s_q       <= s_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            special_q <= special_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.P         = p_q;
    assign bus.S         = s_q;
    assign bus.sign      = sign_q;
    assign bus.zero      = zero_q;
    assign bus.special   = special_q;
endmodule
